// File: rtl/slot_pkg.sv
// Shared types and default sizes for the slot machine reel controller.
package slot_pkg;
  localparam int DEF_NUM_REELS = 3;
  localparam int DEF_SYM_W     = 3;
  localparam int RNG_W         = 16;

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    STOPPING,
    RESULT
  } state_e;
endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick is high for the cycle the count sits at TICK_DIV-1.
// clr restarts the count so the next tick lands exactly TICK_DIV cycles later.
module tick_prescaler #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = !clr && (cnt_q == LAST);
endmodule

// File: rtl/reel_stop_ctrl.sv
// Slot machine spin sequencer: all reels spin, then stop left to right on random symbols.
// Optional REEL_PAIR_DETECT_EN adds a registered 'pair' output (adjacent match without a win).
module reel_stop_ctrl
  import slot_pkg::*;
#(
  parameter int NUM_REELS = DEF_NUM_REELS,
  parameter int SYM_W     = DEF_SYM_W,
  parameter int TICK_DIV  = 10_000_000,
  parameter int MIN_SPIN  = 16,
  parameter int STOP_GAP  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [RNG_W-1:0]           rand_in,
  output logic                       rng_en,
  output logic [NUM_REELS*SYM_W-1:0] reel_sym,
  output logic [NUM_REELS-1:0]       spinning,
  output logic                       busy,
  output logic                       done,
  output logic                       win
`ifdef REEL_PAIR_DETECT_EN
  ,
  output logic                       pair
`endif
);
  localparam int CNT_W = $clog2(MIN_SPIN + 16);
  localparam int IDX_W = $clog2(NUM_REELS + 1);
  localparam int GAP_W = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           spin_cnt_q, spin_cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic [NUM_REELS*SYM_W-1:0] sym_q, sym_d;
  logic [NUM_REELS-1:0]       spin_q, spin_d;
  logic                       win_q, win_d;
  logic                       pair_q, pair_d;

  logic tick, accept, advance, stop_now, all_eq, adj_eq;
  logic unused_rand;

  assign unused_rand = ^rand_in[RNG_W-1:4];
  assign accept      = (state_q == IDLE) && start;
  assign advance     = tick && (state_q == SPIN || state_q == STOPPING);
  assign stop_now    = tick && (state_q == STOPPING) && (gap_q == '0);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    all_eq = 1'b1;
    adj_eq = 1'b0;
    for (int i = 1; i < NUM_REELS; i++) begin
      if (sym_q[i*SYM_W +: SYM_W] != sym_q[0 +: SYM_W]) all_eq = 1'b0;
      if (sym_q[i*SYM_W +: SYM_W] == sym_q[(i-1)*SYM_W +: SYM_W]) adj_eq = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    spin_cnt_d = spin_cnt_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    sym_d      = sym_q;
    spin_d     = spin_q;
    win_d      = win_q;
    pair_d     = pair_q;

    // A reel being stopped takes the random word instead of its increment.
    for (int i = 0; i < NUM_REELS; i++) begin
      if (advance && spin_q[i])
        sym_d[i*SYM_W +: SYM_W] = sym_q[i*SYM_W +: SYM_W] + SYM_W'(1);
      if (stop_now && idx_q == IDX_W'(i)) begin
        sym_d[i*SYM_W +: SYM_W] = rand_in[SYM_W-1:0];
        spin_d[i]               = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          spin_cnt_d = CNT_W'(MIN_SPIN) + CNT_W'(rand_in[3:0]);
          spin_d     = '1;
          win_d      = 1'b0;
          pair_d     = 1'b0;
          state_d    = SPIN;
        end
      end
      SPIN: begin
        if (tick) begin
          if (spin_cnt_q != '0) spin_cnt_d = spin_cnt_q - CNT_W'(1);
          if (spin_cnt_q <= CNT_W'(1)) begin
            state_d = STOPPING;
            idx_d   = '0;
            gap_d   = '0;
          end
        end
      end
      STOPPING: begin
        if (stop_now) begin
          gap_d = GAP_W'(STOP_GAP - 1);
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_REELS - 1)) state_d = RESULT;
        end else if (tick) begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      RESULT: begin
        win_d   = all_eq;
        pair_d  = adj_eq && !all_eq;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      spin_cnt_q <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      sym_q      <= '0;
      spin_q     <= '0;
      win_q      <= 1'b0;
      pair_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      spin_cnt_q <= spin_cnt_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      sym_q      <= sym_d;
      spin_q     <= spin_d;
      win_q      <= win_d;
      pair_q     <= pair_d;
    end
  end

  // The generator free-runs while idle so button timing seeds the result.
  assign rng_en   = !reset && (state_q == IDLE || stop_now);
  assign reel_sym = sym_q;
  assign spinning = spin_q;
  assign busy     = (state_q != IDLE);
  assign done     = !reset && (state_q == RESULT);
  assign win      = win_q;
`ifdef REEL_PAIR_DETECT_EN
  assign pair     = pair_q;
`else
  logic unused_pair;
  assign unused_pair = pair_q ^ adj_eq;
`endif
endmodule

// File: tb/tb_reel_stop_ctrl.sv
// Directed bench for reel_stop_ctrl with TICK_DIV=4, MIN_SPIN=2, STOP_GAP=1.
module tb_reel_stop_ctrl;
  localparam int NR = 3;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [15:0]   rand_in;
  logic          rng_en, busy, done, win;
  logic [NR*SW-1:0] reel_sym;
  logic [NR-1:0] spinning;
`ifdef REEL_PAIR_DETECT_EN
  logic          pair;
`endif

  int checks = 0;
  int errors = 0;
  int rng_cnt = 0;
  int done_cnt = 0;

  reel_stop_ctrl #(
    .NUM_REELS(NR), .SYM_W(SW), .TICK_DIV(4), .MIN_SPIN(2), .STOP_GAP(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rand_in(rand_in),
    .rng_en(rng_en), .reel_sym(reel_sym), .spinning(spinning),
    .busy(busy), .done(done), .win(win)
`ifdef REEL_PAIR_DETECT_EN
    , .pair(pair)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && rng_en) rng_cnt <= rng_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct packed {
    logic              rst;
    logic [15:0]       start_rand;
    logic [2:0][15:0]  stops;
    logic [8:0]        exp_spin;
    logic [8:0]        exp_final;
    logic              exp_win;
    logic              exp_pair;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [15:0] sr,
                              input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                              input logic [8:0] es, input logic [8:0] ef,
                              input logic w, input logic p);
    vec_t v;
    v.rst = r; v.start_rand = sr;
    v.stops[0] = s0; v.stops[1] = s1; v.stops[2] = s2;
    v.exp_spin = es; v.exp_final = ef; v.exp_win = w; v.exp_pair = p;
    return v;
  endfunction

  task automatic run(input vec_t v);
    int n, r0, d0;
    logic [2:0] mask;
    if (v.rst) begin
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      #1;
      chk("rst_sym", 32'(reel_sym), 0);
      chk("rst_rng_en", 32'(rng_en), 1);
    end
    n  = 2 + int'(v.start_rand[3:0]);
    r0 = rng_cnt;
    d0 = done_cnt;
    start   = 1'b1;
    rand_in = v.start_rand;
    step(1);
    start = 1'b0;
    chk("accept_busy", 32'(busy), 1);
    chk("accept_spinning", 32'(spinning), 32'h7);
`ifdef REEL_PAIR_DETECT_EN
    chk("accept_pair_clr", 32'(pair), 0);
`endif
    step(4 * n);
    chk("spin_sym", 32'(reel_sym), 32'(v.exp_spin));
    chk("spin_all", 32'(spinning), 32'h7);
    for (int j = 0; j < 3; j++) begin
      rand_in = v.stops[j];
      step(4);
      mask = 3'b111 << (j + 1);
      chk("stop_mask", 32'(spinning), 32'(mask));
      chk("stop_sym", 32'(reel_sym[j*SW +: SW]), 32'(v.stops[j][2:0]));
      chk("stop_done", 32'(done), (j == 2) ? 1 : 0);
    end
    step(1);
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("final_sym", 32'(reel_sym), 32'(v.exp_final));
    chk("win", 32'(win), 32'(v.exp_win));
`ifdef REEL_PAIR_DETECT_EN
    chk("pair", 32'(pair), 32'(v.exp_pair));
`endif
    chk("idle_rng_en", 32'(rng_en), 1);
    chk("rng_pulses", 32'(rng_cnt - r0), 3);
    chk("done_pulses", 32'(done_cnt - d0), 1);
  endtask

  initial begin
    int d0;
    reset   = 1'b1;
    start   = 1'b0;
    rand_in = 16'h0000;
    #1;
    chk("reset_rng_en", 32'(rng_en), 0);
    step(2);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_spinning", 32'(spinning), 0);
    chk("reset_win", 32'(win), 0);

    // {reel2,reel1,reel0}; each spin starts from the previous final symbols.
    vecs[0] = mk(1'b1, 16'h0003, 16'h0005, 16'h0005, 16'h0005, 9'h16D, 9'h16D, 1'b1, 1'b0);
    vecs[1] = mk(1'b0, 16'hA5F3, 16'h0009, 16'h0002, 16'hFFFB, 9'h092, 9'h0D1, 1'b0, 1'b0);
    vecs[2] = mk(1'b0, 16'h0000, 16'h0002, 16'h0002, 16'h0007, 9'h163, 9'h1D2, 1'b0, 1'b1);
    vecs[3] = mk(1'b0, 16'h0007, 16'h0004, 16'h0000, 16'h0004, 9'h01B, 9'h104, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run(vecs[i]);

    // Start during SPIN must not reload spin_cnt; then reset lands mid-STOPPING.
    d0 = done_cnt;
    start   = 1'b1;
    rand_in = 16'h0000;
    step(1);
    start = 1'b0;
    step(2);
    start   = 1'b1;
    rand_in = 16'h000F;
    step(1);
    start = 1'b0;
    step(5);
    chk("busy_ign_sym", 32'(reel_sym), 32'h196);
    rand_in = 16'h0003;
    step(4);
    chk("busy_ign_stop", 32'(spinning), 32'h6);
    chk("busy_ign_sym2", 32'(reel_sym), 32'h1DB);
    reset = 1'b1;
    start = 1'b1;
    #1;
    chk("mid_rst_rng_en", 32'(rng_en), 0);
    chk("mid_rst_done", 32'(done), 0);
    step(1);
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("abort_sym", 32'(reel_sym), 0);
    chk("abort_spinning", 32'(spinning), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_win", 32'(win), 0);
    chk("abort_rng_en", 32'(rng_en), 1);
    step(20);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_idle", 32'(busy), 0);

    // Start coincident with reset in IDLE: reset wins.
    reset   = 1'b1;
    start   = 1'b1;
    rand_in = 16'h0003;
    step(1);
    reset = 1'b0;
    start = 1'b0;
    step(1);
    chk("rst_start_busy", 32'(busy), 0);
    chk("rst_start_spin", 32'(spinning), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
